// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall bubble
// insertion and a saturating bubble counter for performance monitoring.
module id_ex_pipe #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [19:0]     id_ctl,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_shamt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [DW-1:0]   id_busA,
    input  logic [DW-1:0]   id_busB,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc4,
    input  logic            flush,
    output logic            ex_valid,
    output logic [19:0]     ex_ctl,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_shamt,
    output logic [DW-1:0]   ex_busA,
    output logic [DW-1:0]   ex_busB,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc4,
    output logic [4:0]      ex_wreg,
    output logic            stall,
    output logic [CNTW-1:0] bubble_cnt
);
    // Control bundle bit positions
    localparam int R31WR  = 19;
    localparam int MRD_HI = 17;
    localparam int MRD_LO = 16;
    localparam int REGWR  = 12;
    localparam int REGDST = 9;

    logic            valid_q, valid_d;
    logic [19:0]     ctl_q, ctl_d;
    logic [4:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [DW-1:0]   busA_q, busA_d, busB_q, busB_d, imm_q, imm_d, pc4_q, pc4_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            hazard, bubble;

    assign ex_wreg = ctl_q[R31WR]  ? 5'd31 :
                     ctl_q[REGDST] ? rd_q  : rt_q;

    assign hazard = valid_q && (ctl_q[MRD_HI:MRD_LO] != 2'b00) && ctl_q[REGWR]
                 && (ex_wreg != 5'd0)
                 && ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));

    assign stall  = hazard && id_valid && !flush;
    assign bubble = flush || stall;

    always_comb begin
        valid_d = 1'b0;
        ctl_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        shamt_d = '0;
        busA_d  = '0;
        busB_d  = '0;
        imm_d   = '0;
        pc4_d   = '0;
        cnt_d   = cnt_q;
        if (bubble) begin
            // Only count bubbles that displaced a real instruction
            if (id_valid && (cnt_q != {CNTW{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end else begin
            valid_d = id_valid;
            ctl_d   = id_valid ? id_ctl : 20'd0;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            shamt_d = id_shamt;
            busA_d  = id_busA;
            busB_d  = id_busB;
            imm_d   = id_imm;
            pc4_d   = id_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            busA_q  <= '0;
            busB_q  <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            busA_q  <= busA_d;
            busB_q  <= busB_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctl     = ctl_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_shamt   = shamt_q;
    assign ex_busA    = busA_q;
    assign ex_busB    = busB_q;
    assign ex_imm     = imm_q;
    assign ex_pc4     = pc4_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus random traffic against a
// cycle-level reference model; a CNTW=4 copy exercises counter saturation.
module tb_id_ex_pipe;
    localparam int DW = 32;

    // Control field encodings used to build instructions
    localparam logic [19:0] C_R31WR  = 20'h1 << 19;
    localparam logic [19:0] C_LOAD   = 20'h1 << 16;
    localparam logic [19:0] C_MEMTOR = 20'h1 << 11;
    localparam logic [19:0] C_REGWR  = 20'h1 << 12;
    localparam logic [19:0] C_ALUSRC = 20'h1 << 10;
    localparam logic [19:0] C_REGDST = 20'h1 << 9;
    localparam logic [19:0] C_JUMP   = 20'h1 << 7;
    localparam logic [19:0] ADDU_CTL = C_REGDST | C_REGWR;
    localparam logic [19:0] LW_CTL   = C_LOAD | C_REGWR | C_ALUSRC | C_MEMTOR;
    localparam logic [19:0] JAL_CTL  = C_R31WR | C_REGWR | C_JUMP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_use_rs, id_use_rt, flush;
    logic [19:0]   id_ctl;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic [DW-1:0] id_busA, id_busB, id_imm, id_pc4;

    logic          ex_valid, stall;
    logic [19:0]   ex_ctl;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
    logic [DW-1:0] ex_busA, ex_busB, ex_imm, ex_pc4;
    logic [15:0]   bubble_cnt;

    logic          s_valid, s_stall;
    logic [19:0]   s_ctl;
    logic [4:0]    s_rs, s_rt, s_rd, s_shamt, s_wreg;
    logic [DW-1:0] s_busA, s_busB, s_imm, s_pc4;
    logic [3:0]    s_cnt;

    id_ex_pipe #(.DW(DW), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctl(id_ctl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_valid(ex_valid), .ex_ctl(ex_ctl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_wreg(ex_wreg), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.DW(DW), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctl(id_ctl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_valid(s_valid), .ex_ctl(s_ctl),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_shamt(s_shamt),
        .ex_busA(s_busA), .ex_busB(s_busB), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .ex_wreg(s_wreg), .stall(s_stall), .bubble_cnt(s_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    logic stall_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what EX should hold, derived from the instruction-level rules
    logic          m_valid;
    logic [19:0]   m_ctl;
    logic [4:0]    m_rs, m_rt, m_rd, m_shamt;
    logic [DW-1:0] m_busA, m_busB, m_imm, m_pc4;
    int            m_cnt16, m_cnt4;

    function automatic logic [4:0] m_dest();
        if (m_ctl[19]) return 5'd31;
        if (m_ctl[9])  return m_rd;
        return m_rt;
    endfunction

    function automatic logic m_stall();
        logic is_load, reads;
        is_load = m_valid && (m_ctl[17:16] != 2'b00) && m_ctl[12] && (m_dest() != 5'd0);
        reads   = (id_use_rs && id_rs == m_dest()) || (id_use_rt && id_rt == m_dest());
        return is_load && reads && id_valid && !flush;
    endfunction

    task automatic m_clear();
        m_valid = 1'b0; m_ctl = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_shamt = '0;
        m_busA = '0; m_busB = '0; m_imm = '0; m_pc4 = '0;
    endtask

    task automatic m_edge();
        if (rst) begin
            m_clear();
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else if (flush || m_stall()) begin
            if (id_valid) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15)     m_cnt4++;
            end
            m_clear();
        end else begin
            m_valid = id_valid;
            m_ctl   = id_valid ? id_ctl : 20'd0;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_shamt = id_shamt;
            m_busA = id_busA; m_busB = id_busB; m_imm = id_imm; m_pc4 = id_pc4;
        end
    endtask

    task automatic cyc();
        logic exp_st;
        @(negedge clk);
        exp_st     = m_stall();
        stall_seen = stall;
        chk("stall", stall, exp_st);
        chk("stall4", s_stall, exp_st);
        @(posedge clk);
        m_edge();
        #1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctl", ex_ctl, m_ctl);
        chk("ex_fields", {ex_rs, ex_rt, ex_rd, ex_shamt}, {m_rs, m_rt, m_rd, m_shamt});
        chk("ex_busAB", {ex_busA, ex_busB}, {m_busA, m_busB});
        chk("ex_immpc", {ex_imm, ex_pc4}, {m_imm, m_pc4});
        chk("ex_wreg", ex_wreg, m_dest());
        chk("bubble_cnt", bubble_cnt, m_cnt16[15:0]);
        chk("bubble_cnt4", s_cnt, m_cnt4[3:0]);
    endtask

    task automatic drive(input logic v, input logic [19:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic fl);
        id_valid = v; id_ctl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_shamt = 5'($urandom); id_use_rs = urs; id_use_rt = urt; flush = fl;
        id_busA = $urandom; id_busB = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    endtask

    initial begin
        m_clear();
        m_cnt16 = 0;
        m_cnt4  = 0;
        stall_seen = 1'b0;

        // Reset with random ID contents
        rst = 1'b1;
        drive(1'b1, 20'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0);
        cyc();
        cyc();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_cnt", bubble_cnt, 16'd0);
        rst = 1'b0;

        // ADDU pass-through
        drive(1'b1, ADDU_CTL, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        id_busA = 32'd5; id_busB = 32'd7;
        cyc();
        chk("addu_busA", ex_busA, 32'd5);
        chk("addu_wreg", ex_wreg, 5'd3);
        chk("addu_stall", stall_seen, 1'b0);

        // Load-use: LW $8 then ADDU reading $8
        drive(1'b1, LW_CTL, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, ADDU_CTL, 5'd8, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("lu_stall", stall_seen, 1'b1);
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_cnt", bubble_cnt, 16'd1);
        cyc();   // same ADDU re-presented
        chk("lu_stall_drop", stall_seen, 1'b0);
        chk("lu_capture", {ex_valid, ex_wreg}, {1'b1, 5'd5});

        // Load to $0 never stalls
        drive(1'b1, LW_CTL, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, ADDU_CTL, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("zero_stall", stall_seen, 1'b0);
        chk("zero_cnt", bubble_cnt, 16'd1);

        // Flush together with a hazard
        drive(1'b1, LW_CTL, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, ADDU_CTL, 5'd9, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("fl_stall", stall_seen, 1'b0);
        chk("fl_bubble", ex_valid, 1'b0);
        chk("fl_cnt", bubble_cnt, 16'd2);

        // JAL writes $31
        drive(1'b1, JAL_CTL, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("jal_wreg", ex_wreg, 5'd31);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 20'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1);
            cyc();
        end
        chk("sat4", s_cnt, 4'd15);
        chk("sat16", bubble_cnt, 16'd19);

        // Reset arriving during a stall
        drive(1'b1, LW_CTL, 5'd4, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, ADDU_CTL, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        chk("rst_mid_stall", stall_seen, 1'b1);
        rst = 1'b0;
        cyc();
        chk("rst_after_stall", stall_seen, 1'b0);
        chk("rst_after_cnt", bubble_cnt, 16'd0);

        // Random traffic; a stalled instruction is held and re-presented
        for (int i = 0; i < 400; i++) begin
            if (stall_seen) begin
                flush = ($urandom_range(0, 7) == 0);
            end else begin
                drive($urandom_range(0, 3) != 0, 20'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
